uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between several byte-stream requesters. It sits between the requester blocks and the UART `tx_data`/`tx_valid`/`tx_ready` handshake. A grant is locked for a whole packet, so bytes from different sources never interleave on the serial line. Packets are delimited by a `last` flag or capped at a maximum length.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: byte width; must match the UART.
- `MAX_PKT_LEN`, default 16: maximum bytes per grant, 1..255. The grant is released after this many bytes even if `last` has not been seen.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i data on bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_valid` in `NUM_REQ`: per-requester byte valid.
- `req_last` in `NUM_REQ`: marks the final byte of a packet; qualified by `req_valid`.
- `req_ready` out `NUM_REQ`: per-requester accept.
- `tx_data` out `DATA_WIDTH`: to the UART transmitter.
- `tx_valid` out 1: to the UART transmitter.
- `tx_ready` in 1: from the UART transmitter.
- `grant_id` out `$clog2(NUM_REQ)`: current or most recent grantee (registered).
- `busy` out 1: high while a grant is held.

## Operation
- A transfer occurs on any cycle with `tx_valid & tx_ready`.
- States are IDLE, HDR and DATA. HDR exists only when `UART_ARB_HEADER_EN` is defined.
- **IDLE**
  - All `req_ready` = 0, `tx_valid` = 0.
  - If any `req_valid` is high, search from `last_grant+1` with wrap-around and take the first requester whose `req_valid` is high.
  - Register it into `grant_id`, clear `beat_cnt`, then go to HDR or DATA.
- **HDR**
  - `tx_data` = `8'hA0 | grant_id`, `tx_valid` = 1, all `req_ready` = 0.
  - On transfer, go to DATA.
- **DATA**
  - Combinational pass-through from the granted requester: `tx_data` = `req_data[grant_id]`, `tx_valid` = `req_valid[grant_id]`, `req_ready[grant_id]` = `tx_ready`.
  - All other `req_ready` = 0.
  - On each transfer, `beat_cnt` increments.
  - If the transfer has `req_last[grant_id]` = 1, or `beat_cnt == MAX_PKT_LEN-1`, then: `last_grant` <= `grant_id`, go to IDLE.
- Granted requester drops `req_valid` mid-packet: grant is held and `tx_valid` = 0 until it returns. There is no timeout.
- Non-granted requesters are never readied and need not hold off. They simply wait for their grant.
- `beat_cnt` width is 8 bits and never wraps, because it is bounded by `MAX_PKT_LEN`.

## Timing
- Reset values:
  - State IDLE; `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
  - `grant_id` = 0, `busy` = 0, `tx_valid` = 0, all `req_ready` = 0, `tx_data` = 0.
- Arbitration latency is 1 cycle: `req_valid` sampled high in IDLE gives `busy` = 1 and `tx_valid` in the next cycle (header or first data byte).
- Between packets there is exactly one IDLE cycle (no transfer) after the ending transfer.
- `busy` = (state != IDLE), registered.
- The DATA path adds zero cycles: `tx_valid`/`tx_data` follow `req_*` in the same cycle.
- Requesters must hold `req_data` and `req_last` stable while `req_valid` is high and `req_ready` is low.
- Reset during a packet aborts it. The next cycle is IDLE with all outputs at their reset values, and the partial packet is not resumed.
- Simultaneous requests are resolved strictly by round-robin from `last_grant`. No requester waits more than `NUM_REQ-1` packets.

## Configuration
- Macro `UART_ARB_HEADER_EN`.
- Defined:
  - The HDR state is compiled in.
  - Every packet is preceded by one source byte, `8'hA0 | grant_id`.
  - The header byte is not counted in `beat_cnt`.
- Undefined: HDR is absent, IDLE goes directly to DATA, and only requester bytes reach the UART.

## Test plan
- **Single requester (header off).** Stimulus: requester 2 sends 0x11, 0x22, 0x33 (last on 0x33), `tx_ready` held 1. Response: `tx_data` sequence 0x11, 0x22, 0x33 in consecutive cycles; `busy` falls the cycle after 0x33; `grant_id` = 2.
- **Contention and round-robin.** Stimulus: after reset, requesters 0, 1 and 3 all request 1-byte packets continuously. Response: grant order 0, 1, 3, 0, 1, 3; one idle cycle between packets.
- **Length cap.** Stimulus: `MAX_PKT_LEN` = 4; requester 1 streams 6 bytes with no `last`, requester 0 also pending. Response: 4 bytes from requester 1, then requester 0's packet, then the remaining 2 bytes from requester 1.
- **Backpressure and gaps.** Stimulus: `tx_ready` toggles 1,0,0,1 while requester 0 drops `req_valid` for 3 cycles mid-packet. Response: no byte lost or duplicated; `req_ready[0]` mirrors `tx_ready` only in DATA; the grant is held throughout.
- **Header mode.** Stimulus: `UART_ARB_HEADER_EN` defined; requester 3 sends 0x55 (last). Response: `tx_data` 0xA3 then 0x55; `req_ready[3]` stays 0 during the header beat.
- **Reset mid-packet.** Stimulus: assert `reset` for 1 cycle after 2 of 5 bytes. Response: next cycle `tx_valid` = 0, `busy` = 0, `grant_id` = 0; the next arbitration favours requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter between NUM_REQ
//   byte-stream requesters. A grant is held for a whole packet, which ends
//   on a byte flagged with req_last or after MAX_PKT_LEN bytes, whichever
//   comes first. Exactly one IDLE cycle separates consecutive packets.
//
//   Optional build macro: UART_ARB_HEADER_EN
//     When defined, each packet is preceded by one source byte
//     (8'hA0 | grant_id). The header byte does not count towards MAX_PKT_LEN.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   req_data   requester i byte on [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid  per-requester byte valid
//   req_last   per-requester end-of-packet flag, qualified by req_valid
//   req_ready  per-requester accept; only the grantee is ever readied
//   tx_data    byte to the UART transmitter
//   tx_valid   byte valid to the UART transmitter
//   tx_ready   UART transmitter accept
//   grant_id   current or most recent grantee (registered)
//   busy       high while a grant is held (registered)
//
// States
//   state  | meaning
//   S_IDLE | no grant; round-robin search over req_valid
//   S_HDR  | sending the source header byte (UART_ARB_HEADER_EN only)
//   S_DATA | grantee bytes passed straight through to the UART
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int            GW        = $clog2(NUM_REQ);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);
  localparam logic [7:0]    CAP_CNT   = 8'(MAX_PKT_LEN - 1);
  localparam logic [7:0]    HDR_BASE  = 8'hA0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef UART_ARB_HEADER_EN
    S_HDR  = 2'd1,
`endif
    S_DATA = 2'd2
  } state_t;

  state_t                state;
  logic [GW-1:0]         last_grant;
  logic [7:0]            beat_cnt;

  logic                  pick_found;
  logic [GW-1:0]         pick_id;
  logic [GW-1:0]         scan_idx;

  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_valid;
  logic                  gnt_last;

  // Round-robin search: first valid requester starting just after the
  // previous grantee, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  // Mux out the grantee's request signals.
  always_comb begin
    gnt_data  = '0;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        gnt_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
      end
    end
  end

  // Output decode. In DATA the grantee path is combinational so a packet
  // streams at full rate with no added latency.
  always_comb begin
    tx_data   = '0;
    tx_valid  = 1'b0;
    req_ready = '0;
    case (state)
`ifdef UART_ARB_HEADER_EN
      S_HDR: begin
        tx_data  = DATA_WIDTH'(HDR_BASE | 8'(grant_id));
        tx_valid = 1'b1;
      end
`endif
      S_DATA: begin
        tx_data  = gnt_data;
        tx_valid = gnt_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = tx_ready && (grant_id == GW'(i));
        end
      end
      default: begin
        tx_data   = '0;
        tx_valid  = 1'b0;
        req_ready = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= LAST_INIT;
      grant_id   <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
`ifdef UART_ARB_HEADER_EN
            state    <= S_HDR;
`else
            state    <= S_DATA;
`endif
          end
        end
`ifdef UART_ARB_HEADER_EN
        // Header is always valid, so tx_ready alone completes it.
        S_HDR: begin
          if (tx_ready) begin
            state <= S_DATA;
          end
        end
`endif
        S_DATA: begin
          if (gnt_valid && tx_ready) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (gnt_last || (beat_cnt == CAP_CNT)) begin
              last_grant <= grant_id;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DW          = 8;
  localparam int MAX_PKT_LEN = 4;
  localparam int GW          = 2;

`ifdef UART_ARB_HEADER_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic [DW-1:0]          tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [GW-1:0]          grant_id;
  logic                   busy;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .MAX_PKT_LEN(MAX_PKT_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_data (req_data),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; bit last; int gap; } ent_t;
  typedef struct { int id; logic [7:0] data; } beat_t;

  ent_t              src_q [NUM_REQ][$];
  int                gap_cnt [NUM_REQ];
  beat_t             obs_q[$];
  beat_t             exp_q[$];
  bit                rdy_pat[$];
  int                cyc;
  int                n_cmp = 0;
  int                n_bad = 0;
  bit                chk_en = 1'b0;
  logic [NUM_REQ-1:0] hs = '0;

  // Packet-level model of the arbiter
  bit m_busy = 1'b0;
  bit m_hdr  = 1'b0;
  int m_gid  = 0;
  int m_last = NUM_REQ - 1;
  int m_sent = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: check every cycle, then advance the model.
  always @(negedge clk) begin : cmp
    logic [7:0]         e_data;
    logic               e_valid;
    logic [NUM_REQ-1:0] e_rdy;
    int                 c;
    bit                 found;
    hs = req_valid & req_ready;
    if (chk_en) begin
      e_data  = 8'h00;
      e_valid = 1'b0;
      e_rdy   = '0;
      if (m_busy && m_hdr) begin
        e_valid = 1'b1;
        e_data  = 8'hA0 | 8'(m_gid);
      end else if (m_busy) begin
        e_valid = req_valid[m_gid];
        e_data  = 8'(req_data >> (m_gid * DW));
        if (tx_ready) e_rdy[m_gid] = 1'b1;
      end
      chk("busy",      32'(busy),      32'(m_busy));
      chk("grant_id",  32'(grant_id),  32'(m_gid));
      chk("tx_valid",  32'(tx_valid),  32'(e_valid));
      chk("tx_data",   32'(tx_data),   32'(e_data));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      if (tx_valid === 1'b1 && tx_ready === 1'b1)
        obs_q.push_back('{int'(grant_id), tx_data});

      if (reset) begin
        m_busy = 1'b0; m_hdr = 1'b0; m_gid = 0; m_last = NUM_REQ - 1; m_sent = 0;
      end else if (!m_busy) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (m_last + k) % NUM_REQ;
          if (!found && req_valid[c]) begin
            found = 1'b1;
            m_gid = c;
          end
        end
        if (found) begin
          m_busy = 1'b1; m_hdr = HDR_ON; m_sent = 0;
        end
      end else if (m_hdr) begin
        if (tx_ready) m_hdr = 1'b0;
      end else if (req_valid[m_gid] && tx_ready) begin
        m_sent++;
        if (req_last[m_gid] || m_sent == MAX_PKT_LEN) begin
          m_busy = 1'b0;
          m_last = m_gid;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0 && gap_cnt[i] == 0) begin
        req_valid[i]           = 1'b1;
        req_data[i*DW +: DW]   = src_q[i][0].data;
        req_last[i]            = src_q[i][0].last;
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = 8'h00;
        req_last[i]            = 1'b0;
      end
    end
    tx_ready = rdy_pat[cyc % rdy_pat.size()];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i] && src_q[i].size() > 0) begin
        src_q[i].delete(0);
        gap_cnt[i] = (src_q[i].size() > 0) ? src_q[i][0].gap : 0;
      end else if (gap_cnt[i] > 0) begin
        gap_cnt[i]--;
      end
    end
    drive();
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit last, input int gap);
    src_q[r].push_back('{d, last, gap});
    if (src_q[r].size() == 1) gap_cnt[r] = gap;
  endtask

  task automatic ex(input int id, input logic [7:0] d);
    exp_q.push_back('{id, d});
  endtask

  task automatic ex_hdr(input int id);
    if (HDR_ON) exp_q.push_back('{id, 8'hA0 | 8'(id)});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (src_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_ready(input bit p0, input bit p1, input bit p2, input bit p3);
    rdy_pat.delete();
    rdy_pat.push_back(p0); rdy_pat.push_back(p1);
    rdy_pat.push_back(p2); rdy_pat.push_back(p3);
    cyc = 0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      if (all_empty() && !m_busy) done = 1'b1;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_stream(input string name);
    int n;
    chk({name, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_id"},   32'(obs_q[i].id),   32'(exp_q[i].id));
      chk({name, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int  want;
    bit  hit;
    reset     = 1'b1;
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    cyc       = 0;
    for (int i = 0; i < NUM_REQ; i++) gap_cnt[i] = 0;
    set_ready(1, 1, 1, 1);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_grant_id",  32'(grant_id),  32'd0);
    chk("rst_tx_valid",  32'(tx_valid),  32'd0);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single requester
    push(2, 8'h11, 0, 0); push(2, 8'h22, 0, 0); push(2, 8'h33, 1, 0);
    drive();
    ex_hdr(2); ex(2, 8'h11); ex(2, 8'h22); ex(2, 8'h33);
    run_until_done("single", 50);
    check_stream("single");
    chk("single_grant_id", 32'(grant_id), 32'd2);
    chk("single_busy",     32'(busy),     32'd0);

    // Contention and round-robin from reset
    do_reset();
    push(0, 8'h01, 1, 0); push(0, 8'h02, 1, 0);
    push(1, 8'h11, 1, 0); push(1, 8'h12, 1, 0);
    push(3, 8'h31, 1, 0); push(3, 8'h32, 1, 0);
    drive();
    ex_hdr(0); ex(0, 8'h01); ex_hdr(1); ex(1, 8'h11); ex_hdr(3); ex(3, 8'h31);
    ex_hdr(0); ex(0, 8'h02); ex_hdr(1); ex(1, 8'h12); ex_hdr(3); ex(3, 8'h32);
    run_until_done("rr", 100);
    check_stream("rr");

    // Length cap: requester 1 alone first, then requester 0 joins
    push(1, 8'h41, 0, 0); push(1, 8'h42, 0, 0); push(1, 8'h43, 0, 0);
    push(1, 8'h44, 0, 0); push(1, 8'h45, 0, 0); push(1, 8'h46, 1, 0);
    drive();
    tick();
    push(0, 8'h07, 1, 0);
    drive();
    ex_hdr(1); ex(1, 8'h41); ex(1, 8'h42); ex(1, 8'h43); ex(1, 8'h44);
    ex_hdr(0); ex(0, 8'h07);
    ex_hdr(1); ex(1, 8'h45); ex(1, 8'h46);
    run_until_done("cap", 100);
    check_stream("cap");

    // Backpressure and a 3-cycle valid gap
    set_ready(1, 0, 0, 1);
    push(0, 8'h51, 0, 0); push(0, 8'h52, 0, 0); push(0, 8'h53, 0, 3);
    push(0, 8'h54, 0, 0); push(0, 8'h55, 1, 0);
    drive();
    ex_hdr(0); ex(0, 8'h51); ex(0, 8'h52); ex(0, 8'h53); ex(0, 8'h54); ex(0, 8'h55);
    run_until_done("bp", 200);
    check_stream("bp");
    set_ready(1, 1, 1, 1);

    // Single byte from requester 3 (header beat when enabled)
    push(3, 8'h55, 1, 0);
    drive();
    ex_hdr(3); ex(3, 8'h55);
    run_until_done("hdr", 50);
    check_stream("hdr");

    // Reset after two data bytes of a five-byte packet
    push(2, 8'h61, 0, 0); push(2, 8'h62, 0, 0); push(2, 8'h63, 0, 0);
    push(2, 8'h64, 0, 0); push(2, 8'h65, 1, 0);
    drive();
    ex_hdr(2); ex(2, 8'h61); ex(2, 8'h62);
    want = HDR_ON ? 3 : 2;
    hit  = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      tick();
      if (obs_q.size() >= want) hit = 1'b1;
    end
    chk("rst_mid_reached", 32'(hit), 32'd1);
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].delete();
      gap_cnt[i] = 0;
    end
    drive();
    tx_ready = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_busy",     32'(busy),     32'd0);
    chk("rst_mid_grant_id", 32'(grant_id), 32'd0);
    check_stream("rst_mid_pre");
    push(1, 8'h71, 1, 0);
    push(0, 8'h70, 1, 0);
    drive();
    ex_hdr(0); ex(0, 8'h70); ex_hdr(1); ex(1, 8'h71);
    run_until_done("rst_mid_post", 50);
    check_stream("rst_mid_post");

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
